sphere_scene_scheduler: RTL and testbench

- Sequences one shared combinational ray_sphere_intersect instance over a small on-chip table of up to NUM_SPHERES spheres.
- Accepts one ray per transaction over a valid/ready handshake, presents one sphere per cycle to the intersector, and tracks the nearest positive hit.
- Returns hit flag, t and sphere index on a valid/ready result port.
- Sits between the ray generator and the shading/pixel stage.

---
 rtl/sphere_scene_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_sphere_scene_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sphere_scene_scheduler.sv
// Scans a small sphere table through one shared ray/sphere intersector,
// one entry per cycle, and returns the nearest hit over a valid/ready port.
module sphere_scene_scheduler #(
  parameter int NUM_SPHERES = 4,
  parameter int IDX_W       = $clog2(NUM_SPHERES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfgWe,
  input  logic [IDX_W-1:0]        cfgIdx,
  input  logic                    cfgEn,
  input  logic signed [11:0]      cfgCx,
  input  logic signed [11:0]      cfgCy,
  input  logic signed [11:0]      cfgCz,
  input  logic signed [11:0]      cfgRadius,
  output logic                    cfgBusy,
  input  logic                    rayValid,
  output logic                    rayReady,
  input  logic signed [11:0]      rayOx,
  input  logic signed [11:0]      rayOy,
  input  logic signed [11:0]      rayOz,
  input  logic signed [11:0]      rayDx,
  input  logic signed [11:0]      rayDy,
  input  logic signed [11:0]      rayDz,
  output logic                    isValid,
  output logic signed [11:0]      isOx,
  output logic signed [11:0]      isOy,
  output logic signed [11:0]      isOz,
  output logic signed [11:0]      isDx,
  output logic signed [11:0]      isDy,
  output logic signed [11:0]      isDz,
  output logic signed [11:0]      isCx,
  output logic signed [11:0]      isCy,
  output logic signed [11:0]      isCz,
  output logic signed [11:0]      isRadius,
  input  logic                    isHit,
  input  logic signed [11:0]      isT,
  output logic                    resValid,
  input  logic                    resReady,
  output logic                    resHit,
  output logic signed [11:0]      resT,
  output logic [IDX_W-1:0]        resIdx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         k_q, k_d;
  logic [NUM_SPHERES-1:0]   en_q, en_d;
  logic signed [11:0]       cx_q [NUM_SPHERES];
  logic signed [11:0]       cx_d [NUM_SPHERES];
  logic signed [11:0]       cy_q [NUM_SPHERES];
  logic signed [11:0]       cy_d [NUM_SPHERES];
  logic signed [11:0]       cz_q [NUM_SPHERES];
  logic signed [11:0]       cz_d [NUM_SPHERES];
  logic signed [11:0]       rad_q [NUM_SPHERES];
  logic signed [11:0]       rad_d [NUM_SPHERES];
  logic signed [11:0]       ray_ox_q, ray_ox_d, ray_oy_q, ray_oy_d, ray_oz_q, ray_oz_d;
  logic signed [11:0]       ray_dx_q, ray_dx_d, ray_dy_q, ray_dy_d, ray_dz_q, ray_dz_d;
  logic                     best_hit_q, best_hit_d;
  logic signed [11:0]       best_t_q, best_t_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      en_q       <= '0;
      cx_q       <= '{default: '0};
      cy_q       <= '{default: '0};
      cz_q       <= '{default: '0};
      rad_q      <= '{default: '0};
      ray_ox_q   <= '0;
      ray_oy_q   <= '0;
      ray_oz_q   <= '0;
      ray_dx_q   <= '0;
      ray_dy_q   <= '0;
      ray_dz_q   <= '0;
      best_hit_q <= 1'b0;
      best_t_q   <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      en_q       <= en_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cz_q       <= cz_d;
      rad_q      <= rad_d;
      ray_ox_q   <= ray_ox_d;
      ray_oy_q   <= ray_oy_d;
      ray_oz_q   <= ray_oz_d;
      ray_dx_q   <= ray_dx_d;
      ray_dy_q   <= ray_dy_d;
      ray_dz_q   <= ray_dz_d;
      best_hit_q <= best_hit_d;
      best_t_q   <= best_t_d;
      best_idx_q <= best_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    en_d       = en_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    cz_d       = cz_q;
    rad_d      = rad_q;
    ray_ox_d   = ray_ox_q;
    ray_oy_d   = ray_oy_q;
    ray_oz_d   = ray_oz_q;
    ray_dx_d   = ray_dx_q;
    ray_dy_d   = ray_dy_q;
    ray_dz_d   = ray_dz_q;
    best_hit_d = best_hit_q;
    best_t_d   = best_t_q;
    best_idx_d = best_idx_q;
    rayReady   = 1'b0;
    resValid   = 1'b0;
    isValid    = 1'b0;
    isCx       = '0;
    isCy       = '0;
    isCz       = '0;
    isRadius   = '0;

    case (state_q)
      ST_IDLE: begin
        rayReady = 1'b1;
        // Table write and ray accept may share an edge; the scan reads the new entry.
        if (cfgWe) begin
          en_d[cfgIdx]  = cfgEn;
          cx_d[cfgIdx]  = cfgCx;
          cy_d[cfgIdx]  = cfgCy;
          cz_d[cfgIdx]  = cfgCz;
          rad_d[cfgIdx] = cfgRadius;
        end
        if (rayValid) begin
          ray_ox_d   = rayOx;
          ray_oy_d   = rayOy;
          ray_oz_d   = rayOz;
          ray_dx_d   = rayDx;
          ray_dy_d   = rayDy;
          ray_dz_d   = rayDz;
          k_d        = '0;
          best_hit_d = 1'b0;
          best_t_d   = '0;
          best_idx_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        isValid  = en_q[k_q];
        isCx     = cx_q[k_q];
        isCy     = cy_q[k_q];
        isCz     = cz_q[k_q];
        isRadius = rad_q[k_q];
        // Strict less-than keeps the lower index on equal t.
        if (en_q[k_q] && isHit && (!best_hit_q || (isT < best_t_q))) begin
          best_hit_d = 1'b1;
          best_t_d   = isT;
          best_idx_d = k_q;
        end
        if (k_q == IDX_W'(NUM_SPHERES - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        resValid = 1'b1;
        if (resReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cfgBusy = (state_q != ST_IDLE);
  assign isOx    = ray_ox_q;
  assign isOy    = ray_oy_q;
  assign isOz    = ray_oz_q;
  assign isDx    = ray_dx_q;
  assign isDy    = ray_dy_q;
  assign isDz    = ray_dz_q;
  assign resHit  = best_hit_q;
  assign resT    = best_t_q;
  assign resIdx  = best_idx_q;

endmodule

// File: tb/tb_sphere_scene_scheduler.sv
// Scoreboard bench for sphere_scene_scheduler: a stand-in intersector reports
// a hit when radius > 0 with t = centre x; a reference model predicts results.
module tb_sphere_scene_scheduler;

  localparam int NS = 4;
  localparam int IW = 2;

  logic clk, rst_n;
  logic cfgWe, cfgEn, cfgBusy;
  logic [IW-1:0] cfgIdx;
  logic signed [11:0] cfgCx, cfgCy, cfgCz, cfgRadius;
  logic rayValid, rayReady;
  logic signed [11:0] rayOx, rayOy, rayOz, rayDx, rayDy, rayDz;
  logic isValid;
  logic signed [11:0] isOx, isOy, isOz, isDx, isDy, isDz, isCx, isCy, isCz, isRadius;
  logic isHit;
  logic signed [11:0] isT;
  logic resValid, resReady, resHit;
  logic signed [11:0] resT;
  logic [IW-1:0] resIdx;

  sphere_scene_scheduler #(.NUM_SPHERES(NS), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfgWe(cfgWe), .cfgIdx(cfgIdx), .cfgEn(cfgEn),
    .cfgCx(cfgCx), .cfgCy(cfgCy), .cfgCz(cfgCz), .cfgRadius(cfgRadius),
    .cfgBusy(cfgBusy),
    .rayValid(rayValid), .rayReady(rayReady),
    .rayOx(rayOx), .rayOy(rayOy), .rayOz(rayOz),
    .rayDx(rayDx), .rayDy(rayDy), .rayDz(rayDz),
    .isValid(isValid),
    .isOx(isOx), .isOy(isOy), .isOz(isOz), .isDx(isDx), .isDy(isDy), .isDz(isDz),
    .isCx(isCx), .isCy(isCy), .isCz(isCz), .isRadius(isRadius),
    .isHit(isHit), .isT(isT),
    .resValid(resValid), .resReady(resReady),
    .resHit(resHit), .resT(resT), .resIdx(resIdx)
  );

  // Intersector stand-in: deliberately ignores isValid so gating is exercised.
  assign isHit = (isRadius > 12'sd0);
  assign isT   = isCx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   c;
    logic [5:0][11:0]     ray;
    logic [NS-1:0]        en;
    logic [NS-1:0][11:0]  cx, cy, cz, r;
    bit                   hit;
    int                   t;
    int                   idx;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active = 0;
  bit   expect_idle = 0;
  bit   rr_rand = 0;
  int   checks = 0;
  int   errors = 0;
  int   mon_k;

  logic [NS-1:0]       sh_en = '0;
  logic [NS-1:0][11:0] sh_cx = '0, sh_cy = '0, sh_cz = '0, sh_r = '0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Nearest hit = minimum t over enabled spheres with positive radius; the
  // reported index is the lowest one achieving that minimum.
  function automatic exp_t with_ref(input exp_t e);
    int mint = 0;
    bit found = 0;
    for (int i = 0; i < NS; i++)
      if (e.en[i] && $signed(e.r[i]) > 0) begin
        if (!found || $signed(e.cx[i]) < mint) mint = $signed(e.cx[i]);
        found = 1;
      end
    e.hit = found;
    e.t   = found ? mint : 0;
    e.idx = 0;
    if (found)
      for (int i = NS - 1; i >= 0; i--)
        if (e.en[i] && $signed(e.r[i]) > 0 && $signed(e.cx[i]) == mint) e.idx = i;
    return e;
  endfunction

  task automatic cfg_write(input int idx, input bit en, input logic [11:0] cx, cy, cz, r,
                           input bit apply);
    cfgWe = 1; cfgIdx = IW'(idx); cfgEn = en;
    cfgCx = cx; cfgCy = cy; cfgCz = cz; cfgRadius = r;
    if (apply) begin
      sh_en[idx] = en; sh_cx[idx] = cx; sh_cy[idx] = cy; sh_cz[idx] = cz; sh_r[idx] = r;
    end
    @(posedge clk); #1;
    cfgWe = 0;
  endtask

  task automatic send_ray(input logic [5:0][11:0] ray, input bit wcfg, input int ci,
                          input bit cen, input logic [11:0] ccx, ccy, ccz, cr);
    exp_t e;
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rayReady) begin ok = 1; break; end
    end
    if (!ok) begin fail_now("ray_ready_wait"); return; end
    rayOx = ray[0]; rayOy = ray[1]; rayOz = ray[2];
    rayDx = ray[3]; rayDy = ray[4]; rayDz = ray[5];
    rayValid = 1;
    if (wcfg) begin
      cfgWe = 1; cfgIdx = IW'(ci); cfgEn = cen;
      cfgCx = ccx; cfgCy = ccy; cfgCz = ccz; cfgRadius = cr;
      sh_en[ci] = cen; sh_cx[ci] = ccx; sh_cy[ci] = ccy; sh_cz[ci] = ccz; sh_r[ci] = cr;
    end
    e.c = cyc; e.ray = ray; e.en = sh_en;
    e.cx = sh_cx; e.cy = sh_cy; e.cz = sh_cz; e.r = sh_r;
    q.push_back(with_ref(e));
    @(posedge clk); #1;
    rayValid = 0;
    cfgWe = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !active && rayReady && !resValid) return;
    end
    fail_now("drain_wait");
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    q.delete();
    active = 0;
    expect_idle = 0;
    sh_en = '0; sh_cx = '0; sh_cy = '0; sh_cz = '0; sh_r = '0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_rayReady", rayReady, 1);
    chk("rst_cfgBusy", cfgBusy, 0);
    chk("rst_resValid", resValid, 0);
    chk("rst_isValid", isValid, 0);
    chk("rst_resHit", resHit, 0);
    chk("rst_resT", int'(resT), 0);
    chk("rst_resIdx", int'(resIdx), 0);
    chk("rst_isOx", int'(isOx), 0);
    chk("rst_isDz", int'(isDz), 0);
  endtask

  function automatic logic [5:0][11:0] rand_ray();
    logic [5:0][11:0] r;
    for (int i = 0; i < 6; i++) r[i] = 12'($urandom);
    return r;
  endfunction

  // Monitor: pops the scoreboard when a result appears and checks scan traffic.
  always @(negedge clk) begin
    logic [5:0][11:0] dray;
    if (rst_n) begin
      dray = {isDz, isDy, isDx, isOz, isOy, isOx};
      if (expect_idle) begin
        chk("idle_after_xfer", rayReady, 1);
        chk("idle_resValid", resValid, 0);
        expect_idle = 0;
      end
      if (resValid) begin
        if (!active) begin
          if (q.size() == 0) chk("unexpected_res", resValid, 0);
          else begin
            cur = q.pop_front();
            active = 1;
            chk("latency", cyc - cur.c, NS + 1);
          end
        end
        if (active) begin
          chk("res_hit", resHit, int'(cur.hit));
          chk("res_t", int'(resT), cur.t);
          chk("res_idx", int'(resIdx), cur.idx);
          chk("done_rayReady", rayReady, 0);
          chk("done_busy", cfgBusy, 1);
          chk("done_isValid", isValid, 0);
          if (resReady) begin
            active = 0;
            expect_idle = 1;
          end
        end
      end else begin
        if (active) chk("res_held", resValid, 1);
        mon_k = (q.size() > 0) ? cyc - q[0].c - 1 : -1;
        if (mon_k >= 0 && mon_k < NS) begin
          chk("scan_isValid", isValid, int'(q[0].en[mon_k]));
          chk("scan_isCx", int'(isCx), int'($signed(q[0].cx[mon_k])));
          chk("scan_isCy", int'(isCy), int'($signed(q[0].cy[mon_k])));
          chk("scan_isCz", int'(isCz), int'($signed(q[0].cz[mon_k])));
          chk("scan_isRadius", int'(isRadius), int'($signed(q[0].r[mon_k])));
          chk("scan_ray", int'(dray), int'(q[0].ray));
          chk("scan_rayReady", rayReady, 0);
        end else begin
          chk("idle_isValid", isValid, 0);
          chk("idle_isRadius", int'(isRadius), 0);
        end
      end
    end
  end

  always @(posedge clk) if (rr_rand) #2 resReady = 1'($urandom_range(0, 1));

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0][11:0] ray;
    bit got;
    rst_n = 0; cfgWe = 0; cfgIdx = '0; cfgEn = 0;
    cfgCx = '0; cfgCy = '0; cfgCz = '0; cfgRadius = '0;
    rayValid = 0; rayOx = '0; rayOy = '0; rayOz = '0; rayDx = '0; rayDy = '0; rayDz = '0;
    resReady = 1;
    @(posedge clk); #1;
    do_reset(3);
    check_reset_state();

    // Empty table: no hit, isValid low all scan cycles.
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    wait_done();

    // Spheres 1 (t=40) and 3 (t=25): nearest is 3.
    cfg_write(1, 1, 12'd40, 12'd1, 12'd2, 12'd5, 1);
    cfg_write(3, 1, 12'd25, 12'd3, 12'd4, 12'd5, 1);
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    wait_done();

    // Tie at t=30 between 0 and 2 keeps index 0.
    cfg_write(1, 0, '0, '0, '0, '0, 1);
    cfg_write(3, 0, '0, '0, '0, '0, 1);
    cfg_write(0, 1, 12'd30, 12'd7, 12'd8, 12'd6, 1);
    cfg_write(2, 1, 12'd30, 12'd9, 12'd10, 12'd6, 1);
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    wait_done();

    // Backpressure in DONE; a write to entry 2 there must be ignored.
    resReady = 0;
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resValid) begin got = 1; break; end
    end
    if (!got) fail_now("res_valid_wait");
    repeat (3) @(negedge clk);
    cfg_write(2, 0, 12'd99, 12'd99, 12'd99, 12'd1, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #2 resReady = 1;
    wait_done();
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    wait_done();

    // Reset during scan cycle 2 abandons the ray and clears the table.
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    @(posedge clk); @(posedge clk); #1;
    do_reset(2);
    check_reset_state();
    repeat (8) @(negedge clk);
    send_ray(rand_ray(), 0, 0, 0, '0, '0, '0, '0);
    wait_done();

    // Table write on the accepting edge is visible to the scan.
    send_ray(rand_ray(), 1, 0, 1, 12'd10, 12'd1, 12'd1, 12'd4);
    wait_done();

    // Randomised traffic with random result backpressure.
    rr_rand = 1;
    for (int n = 0; n < 40; n++) begin
      wait_done();
      repeat ($urandom_range(0, 2)) begin
        ray = rand_ray();
        cfg_write($urandom_range(0, NS - 1), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 7)) : ray[0],
                  ray[1], ray[2], 12'(int'($urandom_range(0, 43)) - 3), 1);
      end
      ray = rand_ray();
      if ($urandom_range(0, 3) == 0)
        send_ray(ray, 1, $urandom_range(0, NS - 1), 1, 12'($urandom_range(0, 7)),
                 ray[4], ray[5], 12'($urandom_range(1, 20)));
      else
        send_ray(ray, 0, 0, 0, '0, '0, '0, '0);
    end
    rr_rand = 0;
    @(posedge clk); #3 resReady = 1;
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
